// File: rtl/cpu_defs.sv
// cpu_defs: shared definitions for the fetch stage and its decoder.
// Holds the FSM state encoding, default widths and ROM word field offsets.
package cpu_defs;

    // Two-phase instruction sequencing
    typedef enum logic {
        FETCH   = 1'b0,
        EXECUTE = 1'b1
    } fetch_state_t;

    localparam int PC_WIDTH_D    = 8;
    localparam int INSTR_WIDTH_D = 5;
    localparam int IMM_WIDTH_D   = 8;

    // ROM word layout: {opcode, immediate}; immediate sits at bit 0
    localparam int ROM_IMM_LSB = 0;

    // Opcode field starts right above the immediate
    function automatic int rom_opc_lsb(input int imm_w);
        return ROM_IMM_LSB + imm_w;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: ROM bus plus decoder control bundle around the fetch stage.
// STALL exists only when FETCH_STALL_EN is defined.
interface fetch_unit_if #(
    parameter int PC_WIDTH    = cpu_defs::PC_WIDTH_D,
    parameter int INSTR_WIDTH = cpu_defs::INSTR_WIDTH_D,
    parameter int IMM_WIDTH   = cpu_defs::IMM_WIDTH_D
);
    logic [PC_WIDTH-1:0]              ROM_ADDR;
    logic [INSTR_WIDTH+IMM_WIDTH-1:0] ROM_DATA;
    logic [INSTR_WIDTH-1:0]           INSTRUCTION;
    logic [IMM_WIDTH-1:0]             IMM;
    logic                             EXEC_EN;
    logic                             CE_PC;
    logic                             PC_SEL;
    logic                             CE_STACK;
    logic                             nRW_STACK;
    logic                             STACK_SEL;
    logic                             RESET_INSTR;
    logic                             STACK_ERR;
`ifdef FETCH_STALL_EN
    logic                             STALL;
`endif

    // Fetch-unit side
    modport master (
`ifdef FETCH_STALL_EN
        input  STALL,
`endif
        output ROM_ADDR, INSTRUCTION, IMM, EXEC_EN, STACK_ERR,
        input  ROM_DATA, CE_PC, PC_SEL, CE_STACK, nRW_STACK, STACK_SEL, RESET_INSTR
    );

    // ROM / decoder side
    modport slave (
`ifdef FETCH_STALL_EN
        output STALL,
`endif
        input  ROM_ADDR, INSTRUCTION, IMM, EXEC_EN, STACK_ERR,
        output ROM_DATA, CE_PC, PC_SEL, CE_STACK, nRW_STACK, STACK_SEL, RESET_INSTR
    );

endinterface

// File: rtl/fetch_unit_return_stack.sv
// return_stack: LIFO of return addresses. Pointer is reset asynchronously;
// entry storage is not reset (contents are don't-care after reset).
// Overflowing pushes and underflowing pops are ignored; the caller flags them.
module return_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);
    localparam int SPW = $clog2(DEPTH) + 1;
    localparam int IDW = SPW - 1;

    logic [SPW-1:0] sp;
    logic [W-1:0]   mem [DEPTH];
    logic [IDW-1:0] top_idx;

    assign full    = (sp == SPW'(DEPTH));
    assign empty   = (sp == '0);
    // When full the low bits wrap to 0, so minus one lands on the last entry
    assign top_idx = sp[IDW-1:0] - IDW'(1);
    assign top     = mem[top_idx];

    // Stack pointer: clear wins, then push, then pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sp <= '0;
        else if (clear)
            sp <= '0;
        else if (push && !full)
            sp <= sp + SPW'(1);
        else if (pop && !empty)
            sp <= sp - SPW'(1);
    end

    // Entry write on an accepted push
    always_ff @(posedge clk) begin
        if (push && !full && !clear)
            mem[sp[IDW-1:0]] <= data_in;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC / IR holder, two-cycle FETCH/EXECUTE sequencer and
// PC-control (JMP, CALL, RET, software reset) with a return-address stack.
// Optional macro FETCH_STALL_EN adds a STALL input that freezes FETCH.
module fetch_unit
    import cpu_defs::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_D,
    parameter int INSTR_WIDTH = INSTR_WIDTH_D,
    parameter int IMM_WIDTH   = IMM_WIDTH_D,
    parameter int STACK_DEPTH = 8
) (
    input  logic          CLK,
    input  logic          RST,
    fetch_unit_if.master  bus
);
    localparam int OPC_LSB = rom_opc_lsb(IMM_WIDTH);

    fetch_state_t          state, state_nxt;
    logic [PC_WIDTH-1:0]   pc, pc_nxt, pc_inc;
    logic [INSTR_WIDTH-1:0] ir_op;
    logic [IMM_WIDTH-1:0]  ir_imm;
    logic                  stack_err;
    logic                  stall;
    logic                  exec;
    logic                  st_push, st_pop, st_clr, err_set;
    logic                  st_full, st_empty;
    logic [PC_WIDTH-1:0]   st_top;

`ifdef FETCH_STALL_EN
    assign stall = bus.STALL;
`else
    assign stall = 1'b0;
`endif

    assign exec   = (state == EXECUTE);
    assign pc_inc = pc + PC_WIDTH'(1);

    assign bus.ROM_ADDR    = pc;
    assign bus.INSTRUCTION = ir_op;
    assign bus.IMM         = ir_imm;
    assign bus.EXEC_EN     = exec;
    assign bus.STACK_ERR   = stack_err;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= FETCH;
        else
            state <= state_nxt;
    end

    // Next state: FETCH waits out stalls, EXECUTE always lasts one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:   if (!stall) state_nxt = EXECUTE;
            EXECUTE: state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    // PC-control priority decode; stack side effects only take hold in EXECUTE
    always_comb begin
        pc_nxt  = pc_inc;
        st_push = 1'b0;
        st_pop  = 1'b0;
        st_clr  = 1'b0;
        err_set = 1'b0;
        if (!bus.RESET_INSTR) begin
            pc_nxt = '0;
            st_clr = 1'b1;
        end else if (bus.CE_PC && bus.PC_SEL) begin
            if (!st_empty) begin
                st_pop = 1'b1;
                pc_nxt = st_top;
            end else begin
                err_set = 1'b1;
            end
        end else if (bus.CE_PC && bus.CE_STACK && bus.nRW_STACK && bus.STACK_SEL) begin
            pc_nxt = ir_imm[PC_WIDTH-1:0];
            if (!st_full) st_push = 1'b1;
            else          err_set = 1'b1;
        end else if (bus.CE_PC) begin
            pc_nxt = ir_imm[PC_WIDTH-1:0];
        end
    end

    // PC advances once per instruction, at the end of EXECUTE
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            pc <= '0;
        else if (exec)
            pc <= pc_nxt;
    end

    // IR loads at the end of an unstalled FETCH and holds otherwise
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ir_op  <= '0;
            ir_imm <= '0;
        end else if (!exec && !stall) begin
            ir_op  <= bus.ROM_DATA[OPC_LSB +: INSTR_WIDTH];
            ir_imm <= bus.ROM_DATA[ROM_IMM_LSB +: IMM_WIDTH];
        end
    end

    // Sticky stack error, cleared only by reset or the software reset opcode
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            stack_err <= 1'b0;
        else if (exec && st_clr)
            stack_err <= 1'b0;
        else if (exec && err_set)
            stack_err <= 1'b1;
    end

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_WIDTH)
    ) u_stack (
        .clk     (CLK),
        .rst     (RST),
        .clear   (exec && st_clr),
        .push    (exec && st_push),
        .pop     (exec && st_pop),
        .data_in (pc_inc),
        .top     (st_top),
        .full    (st_full),
        .empty   (st_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed program run through fetch_unit with a tiny decoder
// model and a ROM array. Covers NOP stepping, JMP, CALL/RET, RET underflow,
// CALL overflow, PC wrap, software reset, hardware reset mid-instruction and
// (with FETCH_STALL_EN) fetch stalls.
module tb_fetch_unit;
    localparam int PCW = 8;
    localparam int IW  = 5;
    localparam int MW  = 8;

    localparam logic [IW-1:0] OP_RST  = 5'd0;
    localparam logic [IW-1:0] OP_NOP  = 5'd1;
    localparam logic [IW-1:0] OP_JMP  = 5'd2;
    localparam logic [IW-1:0] OP_CALL = 5'd3;
    localparam logic [IW-1:0] OP_RET  = 5'd4;
    localparam logic [IW-1:0] OP_PUSH = 5'd5;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [IW+MW-1:0] rom [256];

    fetch_unit_if #(.PC_WIDTH(PCW), .INSTR_WIDTH(IW), .IMM_WIDTH(MW)) bus ();

    fetch_unit #(
        .PC_WIDTH(PCW), .INSTR_WIDTH(IW), .IMM_WIDTH(MW), .STACK_DEPTH(8)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    assign bus.ROM_DATA = rom[bus.ROM_ADDR];

    // Minimal decoder model
    always_comb begin
        bus.CE_PC       = 1'b0;
        bus.PC_SEL      = 1'b0;
        bus.CE_STACK    = 1'b0;
        bus.nRW_STACK   = 1'b0;
        bus.STACK_SEL   = 1'b0;
        bus.RESET_INSTR = 1'b1;
        case (bus.INSTRUCTION)
            OP_RST:  bus.RESET_INSTR = 1'b0;
            OP_JMP:  bus.CE_PC = 1'b1;
            OP_CALL: begin
                bus.CE_PC = 1'b1; bus.CE_STACK = 1'b1;
                bus.nRW_STACK = 1'b1; bus.STACK_SEL = 1'b1;
            end
            OP_RET: begin
                bus.CE_PC = 1'b1; bus.PC_SEL = 1'b1;
                bus.CE_STACK = 1'b1; bus.STACK_SEL = 1'b1;
            end
            OP_PUSH: begin
                bus.CE_STACK = 1'b1; bus.nRW_STACK = 1'b1;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge in FETCH; runs one full instruction
    task automatic step(input string tag, input logic [7:0] exp_pc);
        chk({tag, ".addr_f"}, 32'(bus.ROM_ADDR), 32'(exp_pc));
        chk({tag, ".en_f"},   32'(bus.EXEC_EN),  32'd0);
        @(negedge CLK);
        chk({tag, ".en_x"},   32'(bus.EXEC_EN),  32'd1);
        chk({tag, ".addr_x"}, 32'(bus.ROM_ADDR), 32'(exp_pc));
        @(negedge CLK);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = {OP_NOP, 8'h00};
        rom[8'h05] = {OP_JMP,  8'h40};
        rom[8'h40] = {OP_JMP,  8'h10};
        rom[8'h10] = {OP_CALL, 8'h20};
        rom[8'h20] = {OP_RET,  8'h00};
        rom[8'h11] = {OP_PUSH, 8'h00};
        rom[8'h12] = {OP_JMP,  8'h30};
        rom[8'h30] = {OP_RET,  8'h00};
        rom[8'h33] = {OP_RST,  8'h00};
        for (int i = 0; i < 9; i++) rom[8'h80 + i] = {OP_CALL, 8'(8'h81 + i)};
        rom[8'h89] = {OP_JMP,  8'hFE};
`ifdef FETCH_STALL_EN
        bus.STALL = 1'b0;
`endif

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst.addr",  32'(bus.ROM_ADDR),    32'd0);
        chk("rst.en",    32'(bus.EXEC_EN),     32'd0);
        chk("rst.instr", 32'(bus.INSTRUCTION), 32'd0);
        chk("rst.imm",   32'(bus.IMM),         32'd0);
        chk("rst.err",   32'(bus.STACK_ERR),   32'd0);
        RST = 1'b0;

        // Linear NOPs 0..4, then JMP 0x40 at address 5
        for (int a = 0; a < 5; a++) step("nop", 8'(a));
        step("jmp5", 8'h05);
        chk("jmp.instr_hold", 32'(bus.INSTRUCTION), 32'(OP_JMP));
        chk("jmp.imm_hold",   32'(bus.IMM),         32'h40);
        step("jmp40", 8'h40);

        // CALL 0x20 from 0x10, RET back to 0x11
        step("call", 8'h10);
        step("ret",  8'h20);
        chk("callret.err", 32'(bus.STACK_ERR), 32'd0);
        step("push", 8'h11);
        step("jmp12", 8'h12);

        // RET on an empty stack falls through with an error
        step("ret_empty", 8'h30);
        chk("underflow.pc",  32'(bus.ROM_ADDR),  32'h31);
        chk("underflow.err", 32'(bus.STACK_ERR), 32'd1);
        step("nop31", 8'h31);
        step("nop32", 8'h32);
        rom[8'h00] = {OP_JMP, 8'h80};
        step("swrst", 8'h33);
        chk("swrst.pc",  32'(bus.ROM_ADDR),  32'd0);
        chk("swrst.err", 32'(bus.STACK_ERR), 32'd0);
        step("jmp80", 8'h00);

        // Nine nested CALLs into an eight-deep stack
        for (int i = 0; i < 8; i++) step("call_n", 8'(8'h80 + i));
        chk("nest8.err", 32'(bus.STACK_ERR), 32'd0);
        step("call_9", 8'h88);
        chk("overflow.pc",  32'(bus.ROM_ADDR),  32'h89);
        chk("overflow.err", 32'(bus.STACK_ERR), 32'd1);

        // PC wrap from 0xFF to 0x00
        step("jmpfe", 8'h89);
        step("nopfe", 8'hFE);
        step("nopff", 8'hFF);
        chk("wrap.pc", 32'(bus.ROM_ADDR), 32'd0);

        // Hardware reset in the middle of EXECUTE
        @(negedge CLK);
        chk("midrst.en_x", 32'(bus.EXEC_EN), 32'd1);
        RST = 1'b1;
        #1;
        chk("midrst.en",   32'(bus.EXEC_EN),     32'd0);
        chk("midrst.addr", 32'(bus.ROM_ADDR),    32'd0);
        chk("midrst.err",  32'(bus.STACK_ERR),   32'd0);
        chk("midrst.ir",   32'(bus.INSTRUCTION), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

`ifdef FETCH_STALL_EN
        // Three stalled FETCH cycles, then normal execution
        bus.STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("stall.addr", 32'(bus.ROM_ADDR), 32'd0);
            chk("stall.en",   32'(bus.EXEC_EN),  32'd0);
        end
        bus.STALL = 1'b0;
        step("stall.resume", 8'h00);
        chk("stall.next", 32'(bus.ROM_ADDR), 32'h80);
`else
        step("after_rst", 8'h00);
        chk("after_rst.next", 32'(bus.ROM_ADDR), 32'h80);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
